parking_lot_controller: RTL and testbench



---
 rtl/parking_lot_controller_pkg.sv | 19 +
 rtl/parking_lot_controller_gate_fsm.sv | 75 +++++++
 rtl/parking_lot_controller.sv | 132 +++++++++++++
 tb/tb_parking_lot_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/parking_lot_controller_pkg.sv
// Shared types and default sizing for the parking lot controller.
// Optional tailgate detection is enabled by defining TAILGATE_DETECT_EN.
package parking_pkg;

    typedef enum logic {
        GATE_IDLE = 1'b0,
        GATE_OPEN = 1'b1
    } gate_state_t;

    localparam int DEF_CAPACITY    = 200;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_TIMEOUT_CYC = 16;

    // Width of a timer that must hold 0..cycles-1; never narrower than 1 bit.
    function automatic int timer_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/parking_lot_controller_gate_fsm.sv
// One barrier lane: IDLE/OPEN state machine with an open-window timeout.
// open and denied are registered; passed_pulse/timeout_pulse flag the closing edge.
module gate_fsm
    import parking_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic allow,
    input  logic pass,
    output logic open,
    output logic denied,
    output logic passed_pulse,
    output logic timeout_pulse
);

    localparam int             TW   = timer_width(TIMEOUT_CYC);
    localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT_CYC - 1);

    gate_state_t   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          denied_q, denied_d;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        denied_d      = 1'b0;
        passed_pulse  = 1'b0;
        timeout_pulse = 1'b0;
        case (state_q)
            GATE_IDLE: begin
                if (req) begin
                    if (allow) begin
                        state_d = GATE_OPEN;
                        timer_d = '0;
                    end else begin
                        denied_d = 1'b1;
                    end
                end
            end
            GATE_OPEN: begin
                // A pass on the timeout edge still counts as a pass.
                if (pass) begin
                    passed_pulse = 1'b1;
                    state_d      = GATE_IDLE;
                end else if (timer_q == TMAX) begin
                    timeout_pulse = 1'b1;
                    state_d       = GATE_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = GATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= GATE_IDLE;
            timer_q  <= '0;
            denied_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            denied_q <= denied_d;
        end
    end

    // The open command is the state register itself, so it doubles as the state view.
    assign open   = (state_q == GATE_OPEN);
    assign denied = denied_q;

endmodule

// File: rtl/parking_lot_controller.sv
// Lot occupancy tracking with entry/exit barrier lanes and free-space export.
// Define TAILGATE_DETECT_EN to add tailgate_alarm/alarm_clr and count stray entries.
module parking_lot_controller
    import parking_pkg::*;
#(
    parameter int CAPACITY    = DEF_CAPACITY,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_req,
    input  logic             entry_pass,
    input  logic             exit_req,
    input  logic             exit_pass,
    output logic             entry_gate_open,
    output logic             exit_gate_open,
    output logic             entry_denied,
    output logic             exit_denied,
    output logic [CNT_W-1:0] occupancy,
    output logic [CNT_W-1:0] free_spaces,
    output logic             full
`ifdef TAILGATE_DETECT_EN
    ,
    output logic             tailgate_alarm,
    input  logic             alarm_clr
`endif
);

    localparam logic [CNT_W-1:0] CAP   = CNT_W'(CAPACITY);
    localparam logic [CNT_W:0]   CAP_X = (CNT_W + 1)'(CAPACITY);

    logic [CNT_W-1:0] occ_q, occ_d;
    logic             entry_passed, entry_timeout;
    logic             exit_passed, exit_timeout;
    logic             occ_inc;

    gate_fsm #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_entry (
        .clk           (clk),
        .rst           (rst),
        .req           (entry_req),
        .allow         (!full),
        .pass          (entry_pass),
        .open          (entry_gate_open),
        .denied        (entry_denied),
        .passed_pulse  (entry_passed),
        .timeout_pulse (entry_timeout)
    );

    gate_fsm #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_exit (
        .clk           (clk),
        .rst           (rst),
        .req           (exit_req),
        .allow         (occ_q != '0),
        .pass          (exit_pass),
        .open          (exit_gate_open),
        .denied        (exit_denied),
        .passed_pulse  (exit_passed),
        .timeout_pulse (exit_timeout)
    );

    // An open entry gate holds one space until pass or timeout.
    always_comb begin
        if (({1'b0, occ_q} + (CNT_W + 1)'(entry_gate_open)) >= CAP_X) begin
            free_spaces = '0;
        end else begin
            free_spaces = CAP - occ_q - CNT_W'(entry_gate_open);
        end
    end

    assign full      = (free_spaces == '0);
    assign occupancy = occ_q;

`ifdef TAILGATE_DETECT_EN
    logic stray_entry;
    logic alarm_q, alarm_d;

    assign stray_entry = entry_pass && !entry_gate_open;
    assign occ_inc     = entry_passed || stray_entry;

    always_comb begin
        alarm_d = alarm_q;
        if (stray_entry) begin
            alarm_d = 1'b1;
        end else if (alarm_clr) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign tailgate_alarm = alarm_q;
`else
    assign occ_inc = entry_passed;
`endif

    // Simultaneous entry and exit passes cancel out.
    always_comb begin
        occ_d = occ_q;
        if (occ_inc && !exit_passed) begin
            if (occ_q != CAP) occ_d = occ_q + CNT_W'(1);
        end else if (exit_passed && !occ_inc) begin
            if (occ_q != '0) occ_d = occ_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    a_lane_exclusive : assert property (@(posedge clk) disable iff (rst)
        !(entry_passed && entry_timeout) && !(exit_passed && exit_timeout));

`ifndef TAILGATE_DETECT_EN
    // Gate admission makes counter saturation impossible without tailgating.
    a_no_sat_high : assert property (@(posedge clk) disable iff (rst)
        !(occ_inc && !exit_passed && occ_q == CAP));
    a_no_sat_low : assert property (@(posedge clk) disable iff (rst)
        !(exit_passed && !occ_inc && occ_q == '0));
`endif

endmodule

// File: tb/tb_parking_lot_controller.sv
// Directed table-driven bench for parking_lot_controller (CAPACITY=3, TIMEOUT_CYC=4).
module tb_parking_lot_controller;

    localparam int CAP  = 3;
    localparam int TMO  = 4;
    localparam int CW   = 8;
    localparam int NVEC = 21;

    logic          clk = 1'b0;
    logic          rst;
    logic          entry_req, entry_pass, exit_req, exit_pass;
    logic          entry_gate_open, exit_gate_open, entry_denied, exit_denied;
    logic [CW-1:0] occupancy, free_spaces;
    logic          full;
`ifdef TAILGATE_DETECT_EN
    logic          tailgate_alarm;
    logic          alarm_clr;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          re, pe, rx, px;
        logic          eo, xo, ed, xd;
        logic [CW-1:0] occ, free;
        logic          full;
    } vec_t;

    vec_t tbl[NVEC];

    parking_lot_controller #(.CAPACITY(CAP), .CNT_W(CW), .TIMEOUT_CYC(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .entry_req       (entry_req),
        .entry_pass      (entry_pass),
        .exit_req        (exit_req),
        .exit_pass       (exit_pass),
        .entry_gate_open (entry_gate_open),
        .exit_gate_open  (exit_gate_open),
        .entry_denied    (entry_denied),
        .exit_denied     (exit_denied),
        .occupancy       (occupancy),
        .free_spaces     (free_spaces),
        .full            (full)
`ifdef TAILGATE_DETECT_EN
        ,
        .tailgate_alarm  (tailgate_alarm),
        .alarm_clr       (alarm_clr)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic re, pe, rx, px, eo, xo, ed, xd,
                                input int occ, free, input logic fl);
        vec_t v;
        v.re = re; v.pe = pe; v.rx = rx; v.px = px;
        v.eo = eo; v.xo = xo; v.ed = ed; v.xd = xd;
        v.occ = CW'(occ); v.free = CW'(free); v.full = fl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic re, pe, rx, px);
        entry_req = re; entry_pass = pe; exit_req = rx; exit_pass = px;
    endtask

    initial begin
        int cnt;
        logic [31:0] got, exp;

        // re pe rx px | eo xo ed xd | occ free full
        tbl[0]  = mk(1,0,0,0, 1,0,0,0, 0,2,0);
        tbl[1]  = mk(1,1,0,0, 0,0,0,0, 1,2,0);
        tbl[2]  = mk(1,0,0,0, 1,0,0,0, 1,1,0);
        tbl[3]  = mk(1,1,0,0, 0,0,0,0, 2,1,0);
        tbl[4]  = mk(1,0,0,0, 1,0,0,0, 2,0,1);
        tbl[5]  = mk(1,1,0,0, 0,0,0,0, 3,0,1);
        tbl[6]  = mk(1,0,0,0, 0,0,1,0, 3,0,1);
        tbl[7]  = mk(1,0,0,0, 0,0,1,0, 3,0,1);
        tbl[8]  = mk(0,0,0,0, 0,0,0,0, 3,0,1);
        tbl[9]  = mk(0,0,1,0, 0,1,0,0, 3,0,1);
        tbl[10] = mk(1,0,1,1, 0,0,1,0, 2,1,0);
        tbl[11] = mk(1,0,1,0, 1,1,0,0, 2,0,1);
        tbl[12] = mk(1,1,1,1, 0,0,0,0, 2,1,0);
        tbl[13] = mk(0,0,0,0, 0,0,0,0, 2,1,0);
        tbl[14] = mk(0,0,1,0, 0,1,0,0, 2,1,0);
        tbl[15] = mk(0,0,1,1, 0,0,0,0, 1,2,0);
        tbl[16] = mk(0,0,1,0, 0,1,0,0, 1,2,0);
        tbl[17] = mk(0,0,1,1, 0,0,0,0, 0,3,0);
        tbl[18] = mk(0,0,1,0, 0,0,0,1, 0,3,0);
        tbl[19] = mk(0,0,0,1, 0,0,0,0, 0,3,0);
        tbl[20] = mk(0,0,0,0, 0,0,0,0, 0,3,0);

        rst = 1'b1;
        drive(0, 0, 0, 0);
`ifdef TAILGATE_DETECT_EN
        alarm_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_gates", {30'd0, entry_gate_open, exit_gate_open}, 32'd0);
        check("reset_denied", {30'd0, entry_denied, exit_denied}, 32'd0);
        check("reset_occ", 32'(occupancy), 32'd0);
        check("reset_free", 32'(free_spaces), 32'(CAP));
        check("reset_full", 32'(full), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].re, tbl[i].pe, tbl[i].rx, tbl[i].px);
            step();
            got = {11'd0, entry_gate_open, exit_gate_open, entry_denied, exit_denied,
                   occupancy, free_spaces, full};
            exp = {11'd0, tbl[i].eo, tbl[i].xo, tbl[i].ed, tbl[i].xd,
                   tbl[i].occ, tbl[i].free, tbl[i].full};
            check($sformatf("vec%0d", i), got, exp);
        end

        // Entry timeout: gate open for TMO cycles, held space returned afterwards.
        drive(1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0);
        check("tmo_open", 32'(entry_gate_open), 32'd1);
        check("tmo_free_held", 32'(free_spaces), 32'(CAP - 1));
        cnt = 1;
        for (int i = 0; i < 20 && entry_gate_open; i++) begin
            step();
            if (entry_gate_open) cnt++;
        end
        check("tmo_open_cycles", 32'(cnt), 32'(TMO));
        check("tmo_free_back", 32'(free_spaces), 32'(CAP));
        check("tmo_occ", 32'(occupancy), 32'd0);

        // Asynchronous reset while a space is held.
        drive(1, 0, 0, 0);
        step();
        drive(1, 1, 0, 0);
        step();
        drive(1, 0, 0, 0);
        step();
        drive(0, 0, 0, 0);
        check("pre_rst_occ", 32'(occupancy), 32'd1);
        check("pre_rst_free", 32'(free_spaces), 32'(CAP - 2));
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_gate", 32'(entry_gate_open), 32'd0);
        check("async_rst_free", 32'(free_spaces), 32'(CAP));
        check("async_rst_occ", 32'(occupancy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_gate", 32'(entry_gate_open), 32'd0);

        // Stray entry pass while the entry lane is idle.
        drive(0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0);
`ifdef TAILGATE_DETECT_EN
        check("stray_occ", 32'(occupancy), 32'd1);
        check("stray_free", 32'(free_spaces), 32'(CAP - 1));
        check("alarm_set", 32'(tailgate_alarm), 32'd1);
        drive(0, 1, 0, 0);
        alarm_clr = 1'b1;
        step();
        drive(0, 0, 0, 0);
        check("alarm_set_wins", 32'(tailgate_alarm), 32'd1);
        check("stray_occ2", 32'(occupancy), 32'd2);
        step();
        alarm_clr = 1'b0;
        check("alarm_clr", 32'(tailgate_alarm), 32'd0);
`else
        check("stray_occ", 32'(occupancy), 32'd0);
        check("stray_free", 32'(free_spaces), 32'(CAP));
        check("stray_gate", 32'(entry_gate_open), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
